// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC / instruction-fetch unit.
// FAULT state exists only when FETCH_MISALIGN_TRAP_EN is defined.
package pc_fetch_pkg;

    localparam int XLEN       = 32;
    localparam int INST_BYTES = 4;

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_HOLD
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        S_FAULT
`endif
    } fetch_state_t;

    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + XLEN'(INST_BYTES);
    endfunction

endpackage

// File: rtl/fetch_inst_buffer.sv
// Decode-side instruction register: holds one fetched word, its PC and
// PC+4 until decode accepts it or a redirect flushes it.
module fetch_inst_buffer
    import pc_fetch_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic            clear,
    input  logic            ready,
    input  logic [XLEN-1:0] load_data,
    input  logic [XLEN-1:0] load_pc,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic [XLEN-1:0] inst_pc_plus4
);

    always_ff @(posedge clock) begin
        if (reset) begin
            inst_valid    <= 1'b0;
            inst_data     <= '0;
            inst_pc       <= '0;
            inst_pc_plus4 <= '0;
        end else if (load) begin
            inst_valid    <= 1'b1;
            inst_data     <= load_data;
            inst_pc       <= load_pc;
            inst_pc_plus4 <= pc_next(load_pc);
        end else if (clear || (inst_valid && ready)) begin
            inst_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding instruction-fetch sequencer.
// Optional misaligned-redirect trap: FETCH_MISALIGN_TRAP_EN.
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic [XLEN-1:0] inst_pc_plus4,
    output logic            misalign_fault
);

    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt, pc_inflight, target;
    logic            kill, kill_nxt;
    logic            req_hs, inst_hs, buf_load;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic target_bad;
    assign target     = redirect_pc;
    assign target_bad = |redirect_pc[1:0];
`else
    assign target = redirect_pc & ~XLEN'(3);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            pc_inflight <= RESET_PC;
            kill        <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            kill  <= kill_nxt;
            if (req_hs)
                pc_inflight <= pc;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        kill_nxt  = kill;
        if (redirect) begin
            pc_nxt = target;
            unique case (state)
                // a response landing with the redirect is simply dropped
                S_WAIT: begin
                    kill_nxt  = !imem_rsp_valid;
                    state_nxt = imem_rsp_valid ? S_FETCH : S_WAIT;
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                S_FAULT: begin
                    kill_nxt  = kill && !imem_rsp_valid;
                    state_nxt = kill_nxt ? S_WAIT : S_FETCH;
                end
`endif
                default: state_nxt = S_FETCH;
            endcase
`ifdef FETCH_MISALIGN_TRAP_EN
            if (target_bad)
                state_nxt = S_FAULT;
`endif
        end else begin
            unique case (state)
                S_FETCH: if (req_hs) state_nxt = S_WAIT;
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        kill_nxt = 1'b0;
                        if (kill) begin
                            state_nxt = S_FETCH;
                        end else begin
                            pc_nxt    = pc_next(pc_inflight);
                            state_nxt = S_HOLD;
                        end
                    end
                end
                S_HOLD: if (inst_hs) state_nxt = S_FETCH;
`ifdef FETCH_MISALIGN_TRAP_EN
                S_FAULT: if (imem_rsp_valid) kill_nxt = 1'b0;
`endif
                default: state_nxt = S_FETCH;
            endcase
        end
    end

    always_comb begin
        imem_req_valid = (state == S_FETCH) && !stall && !redirect;
        imem_req_addr  = pc;
        req_hs         = imem_req_valid && imem_req_ready;
        inst_hs        = inst_valid && inst_ready;
        buf_load       = (state == S_WAIT) && imem_rsp_valid
                         && !kill && !redirect;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_fault = (state == S_FAULT);
`else
        misalign_fault = 1'b0;
`endif
    end

    fetch_inst_buffer u_buf (
        .clock         (clock),
        .reset         (reset),
        .load          (buf_load),
        .clear         (redirect),
        .ready         (inst_ready),
        .load_data     (imem_rsp_data),
        .load_pc       (pc_inflight),
        .inst_valid    (inst_valid),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc),
        .inst_pc_plus4 (inst_pc_plus4)
    );

endmodule
